// File: rtl/grouper_rr_scheduler.sv
// Round-robin scheduler that time-shares one serial-to-parallel grouper between
// NUM_REQ bit-stream requesters and returns each finished group tagged with its source.
module grouper_rr_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int SRC_W        = 2,
    parameter int GROUP_SIZE   = 16,
    parameter int CNT_W        = 5,
    parameter int LOAD_TIMEOUT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_bit,
    input  logic [NUM_REQ-1:0]    req_bit_valid,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    req_bit_ack,
    output logic                  grp_clear,
    output logic                  grp_enable,
    output logic                  grp_element,
    input  logic                  grp_loaded,
    input  logic [GROUP_SIZE-1:0] grp_group,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GROUP_SIZE-1:0] out_data,
    output logic [SRC_W-1:0]      out_src,
    output logic                  err_timeout,
    output logic [2:0]            dbgState
);
    // Output handshake: a group transfers on a cycle where out_valid and out_ready
    // are both high; until then out_valid, out_data and out_src stay unchanged.

    localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        SHIFT     = 3'd2,
        WAIT_LOAD = 3'd3,
        PRESENT   = 3'd4
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [SRC_W-1:0] rrPtr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] cand;
    logic             found;
    logic [CNT_W-1:0] bitCnt;
    logic [TO_W-1:0]  toCnt;
    logic             accept;

    assign dbgState = state;

    // Rotating priority: search starts one past the last winner and wraps.
    always_comb begin
        winner = rrPtr;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = SRC_W'((int'(rrPtr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        nextState   = state;
        grp_clear   = 1'b0;
        grp_enable  = 1'b0;
        grp_element = 1'b0;
        req_bit_ack = '0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) nextState = CLEAR;
            end
            CLEAR: begin
                grp_clear = 1'b1;
                nextState = SHIFT;
            end
            SHIFT: begin
                accept      = req_bit_valid[out_src];
                grp_enable  = accept;
                grp_element = accept & req_bit[out_src];
                req_bit_ack = accept ? (NUM_REQ'(1) << out_src) : '0;
                if (accept && bitCnt == CNT_W'(GROUP_SIZE - 1)) nextState = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                if (grp_loaded) nextState = PRESENT;
                else if (toCnt == TO_W'(LOAD_TIMEOUT - 1)) nextState = IDLE;
            end
            PRESENT: begin
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rrPtr       <= SRC_W'(NUM_REQ - 1);
            grant       <= '0;
            out_src     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
            bitCnt      <= '0;
            toCnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= NUM_REQ'(1) << winner;
                        out_src <= winner;
                        rrPtr   <= winner;
                    end
                end
                CLEAR: begin
                    bitCnt <= '0;
                end
                SHIFT: begin
                    toCnt <= '0;
                    if (accept) bitCnt <= bitCnt + 1'b1;
                end
                WAIT_LOAD: begin
                    if (grp_loaded) begin
                        out_data  <= grp_group;
                        grant     <= '0;
                        out_valid <= 1'b1;
                    end else if (toCnt == TO_W'(LOAD_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grouper_rr_scheduler.sv
// Directed bench for grouper_rr_scheduler: four requester streams, a behavioural
// grouper, and hand-computed expectations for grants, data and timing.
module tb_grouper_rr_scheduler;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_bit = '0;
    logic [3:0]  req_bit_valid = '0;
    logic [3:0]  grant;
    logic [3:0]  req_bit_ack;
    logic        grp_clear;
    logic        grp_enable;
    logic        grp_element;
    logic        grp_loaded;
    logic [15:0] grp_group;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        err_timeout;
    logic [2:0]  dbgState;

    grouper_rr_scheduler dut (
        .clock(clock), .reset(reset), .req(req), .req_bit(req_bit),
        .req_bit_valid(req_bit_valid), .grant(grant), .req_bit_ack(req_bit_ack),
        .grp_clear(grp_clear), .grp_enable(grp_enable), .grp_element(grp_element),
        .grp_loaded(grp_loaded), .grp_group(grp_group), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .err_timeout(err_timeout), .dbgState(dbgState)
    );

    always #5 clock = ~clock;

    // Behavioural grouper: shifts MSB first, reports loaded once 16 bits are in.
    logic [15:0] gReg = '0;
    int          gCnt = 0;
    logic        loadEn = 1'b1;
    always @(posedge clock) begin
        if (grp_clear) begin
            gReg <= '0;
            gCnt <= 0;
        end else if (grp_enable) begin
            gReg <= {gReg[14:0], grp_element};
            gCnt <= gCnt + 1;
        end
    end
    assign grp_group  = gReg;
    assign grp_loaded = loadEn && (gCnt == 16);

    logic [15:0] words[4] = '{16'hA5C3, 16'h3C96, 16'hF00F, 16'h1234};
    int          bitIdx[4] = '{0, 0, 0, 0};
    int          ackCnt[4] = '{0, 0, 0, 0};
    int          clearCnt = 0;
    int          shiftCnt = 0;
    int          waitCnt = 0;
    int          lastLatency = 0;
    logic        validBit = 1'b1;
    logic        toggleMode = 1'b0;
    logic        validSeen = 1'b0;
    logic [3:0]  strayAck = '0;
    logic [3:0]  sampledAck;
    int          numChecks = 0;
    int          numPassed = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got === exp) numPassed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic driveBits();
        if (toggleMode) validBit = (dbgState == ST_SHIFT) ? ~validBit : 1'b1;
        else            validBit = 1'b1;
        req_bit_valid = {4{validBit}};
        for (int i = 0; i < 4; i++) req_bit[i] = words[i][15 - bitIdx[i]];
    endtask

    // One clock: sample mid-cycle, advance streams on consumed bits, redrive.
    task automatic tick();
        @(negedge clock);
        sampledAck = req_bit_ack;
        if (grp_clear) clearCnt++;
        if (dbgState == ST_SHIFT) shiftCnt++;
        if (dbgState == ST_WAIT) waitCnt++;
        if (out_valid) validSeen = 1'b1;
        strayAck = strayAck | (req_bit_ack & ~grant);
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sampledAck[i]) begin
                bitIdx[i] = (bitIdx[i] + 1) % 16;
                ackCnt[i]++;
            end
        end
        driveBits();
    endtask

    task automatic waitGrant(input string tag, input logic [3:0] reqVal, input int expSrc);
        int n;
        req = reqVal;
        n = 0;
        while (grant == 4'b0 && n < 8) begin
            tick();
            n++;
        end
        checkVal({tag, "_grant"}, 32'(grant), 32'(4'b1 << expSrc));
        checkVal({tag, "_src"}, 32'(out_src), 32'(expSrc));
        req = '0;
    endtask

    task automatic runGroup(input string tag, input logic [3:0] reqVal, input int expSrc,
                            input logic [15:0] expData, input int hold);
        int n;
        int clr0;
        int ack0;
        out_ready = (hold == 0);
        waitGrant(tag, reqVal, expSrc);
        clr0 = clearCnt;
        ack0 = ackCnt[expSrc];
        shiftCnt = 0;
        strayAck = '0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        lastLatency = n;
        checkVal({tag, "_data"}, 32'(out_data), 32'(expData));
        checkVal({tag, "_osrc"}, 32'(out_src), 32'(expSrc));
        checkVal({tag, "_gnt_off"}, 32'(grant), 32'h0);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkVal({tag, "_hold_valid"}, 32'(out_valid), 32'h1);
            checkVal({tag, "_hold_data"}, 32'(out_data), 32'(expData));
            checkVal({tag, "_hold_src"}, 32'(out_src), 32'(expSrc));
            checkVal({tag, "_hold_gnt"}, 32'(grant), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        checkVal({tag, "_valid_drop"}, 32'(out_valid), 32'h0);
        checkVal({tag, "_clears"}, 32'(clearCnt - clr0), 32'd1);
        checkVal({tag, "_acks"}, 32'(ackCnt[expSrc] - ack0), 32'd16);
        checkVal({tag, "_stray_ack"}, 32'(strayAck), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        driveBits();
        repeat (3) @(posedge clock);
        #1;
        checkVal("rst_grant", 32'(grant), 32'h0);
        checkVal("rst_outs", 32'({out_valid, grp_clear, grp_enable, grp_element, err_timeout}), 32'h0);
        checkVal("rst_ack", 32'(req_bit_ack), 32'h0);
        checkVal("rst_state", 32'(dbgState), 32'(ST_IDLE));
        checkVal("rst_data", 32'(out_data), 32'h0);
        reset = 1'b0;
        tick();

        // All requesting: rotation from the reset pointer, then wrap.
        runGroup("rr0", 4'b1111, 0, 16'hA5C3, 0);
        runGroup("rr1", 4'b1111, 1, 16'h3C96, 0);
        runGroup("rr2", 4'b1111, 2, 16'hF00F, 0);
        runGroup("rr3", 4'b1111, 3, 16'h1234, 0);
        runGroup("rr4", 4'b1111, 0, 16'hA5C3, 0);

        // Single requester, no stalls: CLEAR + 16 SHIFT + 1 WAIT_LOAD -> out_valid.
        runGroup("single", 4'b0001, 0, 16'hA5C3, 0);
        checkVal("single_latency", 32'(lastLatency), 32'd18);
        checkVal("single_shifts", 32'(shiftCnt), 32'd16);

        // Valid toggling every cycle: half the SHIFT cycles stall.
        toggleMode = 1'b1;
        runGroup("toggle", 4'b0100, 2, 16'hF00F, 0);
        checkVal("toggle_shifts", 32'(shiftCnt), 32'd32);
        checkVal("toggle_latency", 32'(lastLatency), 32'd34);
        toggleMode = 1'b0;

        // Consumer back-pressure for 10 cycles.
        runGroup("stall", 4'b1000, 3, 16'h1234, 10);

        // Grouper never reports loaded.
        loadEn = 1'b0;
        out_ready = 1'b1;
        waitGrant("tmo", 4'b0001, 0);
        waitCnt = 0;
        validSeen = 1'b0;
        n = 0;
        while (!err_timeout && n < 60) begin
            tick();
            n++;
        end
        checkVal("tmo_err", 32'(err_timeout), 32'h1);
        checkVal("tmo_wait_cycles", 32'(waitCnt), 32'd4);
        checkVal("tmo_state", 32'(dbgState), 32'(ST_IDLE));
        checkVal("tmo_no_valid", 32'(validSeen | out_valid), 32'h0);
        checkVal("tmo_grant", 32'(grant), 32'h0);
        loadEn = 1'b1;
        runGroup("after_tmo", 4'b0010, 1, 16'h3C96, 0);
        checkVal("tmo_sticky", 32'(err_timeout), 32'h1);

        // Reset while requester 2 is seven bits into its group.
        waitGrant("mid", 4'b0100, 2);
        n = 0;
        ackCnt[2] = 0;
        while (ackCnt[2] < 7 && n < 40) begin
            tick();
            n++;
        end
        checkVal("mid_enable_pre", 32'(grp_enable), 32'h1);
        reset = 1'b1;
        #1;
        checkVal("mid_rst_grant", 32'(grant), 32'h0);
        checkVal("mid_rst_outs", 32'({out_valid, grp_clear, grp_enable, grp_element, err_timeout}), 32'h0);
        checkVal("mid_rst_ack", 32'(req_bit_ack), 32'h0);
        checkVal("mid_rst_state", 32'(dbgState), 32'(ST_IDLE));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) bitIdx[i] = 0;
        driveBits();
        runGroup("post_rst", 4'b0100, 2, 16'hF00F, 0);
        runGroup("post_rst2", 4'b0001, 0, 16'hA5C3, 0);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
